// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: Decode->Execute pipeline register with hold, bubble and
// optional bubble counter (ID_EX_BUBBLE_CNT_EN); clk/rst_n, StallE/FlushE, <x>D in, <x>E out.
module id_ex_pipe_reg #(
   parameter int WIDTH   = 32,
   parameter int REGADDR = 5,
   parameter int ALUCTRL = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               StallE,
   input  logic               FlushE,
   input  logic               ValidD,
   input  logic [WIDTH-1:0]   RD1D,
   input  logic [WIDTH-1:0]   RD2D,
   input  logic [WIDTH-1:0]   ImmExtD,
   input  logic [WIDTH-1:0]   PCD,
   input  logic [WIDTH-1:0]   PCPlus4D,
   input  logic [REGADDR-1:0] Rs1D,
   input  logic [REGADDR-1:0] Rs2D,
   input  logic [REGADDR-1:0] RdD,
   input  logic               RegWriteD,
   input  logic               MemWriteD,
   input  logic               JumpD,
   input  logic               BranchD,
   input  logic               ALUSrcD,
   input  logic [1:0]         ResultSrcD,
   input  logic [ALUCTRL-1:0] ALUControlD,
   output logic               ValidE,
   output logic [WIDTH-1:0]   RD1E,
   output logic [WIDTH-1:0]   RD2E,
   output logic [WIDTH-1:0]   ImmExtE,
   output logic [WIDTH-1:0]   PCE,
   output logic [WIDTH-1:0]   PCPlus4E,
   output logic [REGADDR-1:0] Rs1E,
   output logic [REGADDR-1:0] Rs2E,
   output logic [REGADDR-1:0] RdE,
   output logic               RegWriteE,
   output logic               MemWriteE,
   output logic               JumpE,
   output logic               BranchE,
   output logic               ALUSrcE,
   output logic [1:0]         ResultSrcE,
   output logic [ALUCTRL-1:0] ALUControlE,
   output logic [31:0]        BubbleCntE
);

   typedef struct packed {
      logic               valid;
      logic [WIDTH-1:0]   rd1;
      logic [WIDTH-1:0]   rd2;
      logic [WIDTH-1:0]   imm;
      logic [WIDTH-1:0]   pc;
      logic [WIDTH-1:0]   pc4;
      logic [REGADDR-1:0] rs1;
      logic [REGADDR-1:0] rs2;
      logic [REGADDR-1:0] rd;
      logic               reg_write;
      logic               mem_write;
      logic               jump;
      logic               branch;
      logic               alu_src;
      logic [1:0]         result_src;
      logic [ALUCTRL-1:0] alu_ctrl;
   } id_ex_t;

   id_ex_t d_bus;
   id_ex_t ex_d;
   id_ex_t ex_q;

   always_comb begin
      d_bus            = '0;
      d_bus.valid      = ValidD;
      d_bus.rd1        = RD1D;
      d_bus.rd2        = RD2D;
      d_bus.imm        = ImmExtD;
      d_bus.pc         = PCD;
      d_bus.pc4        = PCPlus4D;
      d_bus.rs1        = Rs1D;
      d_bus.rs2        = Rs2D;
      d_bus.rd         = RdD;
      d_bus.reg_write  = RegWriteD;
      d_bus.mem_write  = MemWriteD;
      d_bus.jump       = JumpD;
      d_bus.branch     = BranchD;
      d_bus.alu_src    = ALUSrcD;
      d_bus.result_src = ResultSrcD;
      d_bus.alu_ctrl   = ALUControlD;
   end

   // Bubble is all-zero so x0 specifiers never match in the hazard unit.
   always_comb begin
      ex_d = ex_q;
      priority case (1'b1)
         FlushE:  ex_d = '0;
         StallE:  ex_d = ex_q;
         default: ex_d = d_bus;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign ValidE      = ex_q.valid;
   assign RD1E        = ex_q.rd1;
   assign RD2E        = ex_q.rd2;
   assign ImmExtE     = ex_q.imm;
   assign PCE         = ex_q.pc;
   assign PCPlus4E    = ex_q.pc4;
   assign Rs1E        = ex_q.rs1;
   assign Rs2E        = ex_q.rs2;
   assign RdE         = ex_q.rd;
   assign RegWriteE   = ex_q.reg_write;
   assign MemWriteE   = ex_q.mem_write;
   assign JumpE       = ex_q.jump;
   assign BranchE     = ex_q.branch;
   assign ALUSrcE     = ex_q.alu_src;
   assign ResultSrcE  = ex_q.result_src;
   assign ALUControlE = ex_q.alu_ctrl;

`ifdef ID_EX_BUBBLE_CNT_EN
   logic [31:0] bubble_cnt_d;
   logic [31:0] bubble_cnt_q;

   // Saturating: stays at all-ones once reached.
   always_comb begin
      bubble_cnt_d = bubble_cnt_q;
      if (FlushE && (bubble_cnt_q != 32'hFFFF_FFFF))
         bubble_cnt_d = bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bubble_cnt_q <= '0;
      else        bubble_cnt_q <= bubble_cnt_d;
   end

   assign BubbleCntE = bubble_cnt_q;
`else
   assign BubbleCntE = 32'h0;
`endif

endmodule
